// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for updown_mod_counter.
//   cnt_mode_e  : boundary behaviour selected by the 'mode' input
//                 (encoding 2'd3 is reserved and treated as wrap)
//   cnt_state_e : run/done status of the counter
//   ndigits()   : number of decimal digits needed to show a value, used to
//                 size the optional BCD output (COUNTER_BCD_OUT_EN)
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_e;

    function automatic int unsigned ndigits(input int unsigned max);
        int unsigned v;
        int unsigned n;
        v = max;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_reg.sv
// -----------------------------------------------------------------------------
// bin2bcd_reg
// Registered binary-to-BCD converter (double dabble). The output holds the
// decimal digits of bin_i as sampled on the previous rising clock edge,
// least significant digit in bits [3:0].
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; clears the digits to 0
//   bin_i  in   WIDTH-bit binary value
//   bcd_o  out  4*NDIG-bit packed BCD digits (registered)
// -----------------------------------------------------------------------------
module bin2bcd_reg #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned NDIG  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_i,
    output logic [4*NDIG-1:0]     bcd_o
);

    logic [4*NDIG-1:0] bcd_d;
    logic [4*NDIG-1:0] bcd_q;

    // Shift the binary value in MSB first; before each shift any digit >= 5
    // gets +3 so that it carries correctly into the next decimal digit.
    always_comb begin
        bcd_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned d = 0; d < NDIG; d++) begin
                if (bcd_d[4*d +: 4] >= 4'd5) begin
                    bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
                end
            end
            bcd_d = {bcd_d[4*NDIG-2:0], bin_i[WIDTH-1-i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
// Up/down tick counter over 0..MAX_COUNT with wrap, saturate or one-shot
// boundary handling, synchronous clear and parallel load, a registered
// terminal-count pulse and run/done status.
// Priority per edge: reset > clear > load > step.
// Optional build macro: COUNTER_BCD_OUT_EN adds bcd_digits, the registered
// decimal digits of count (one cycle behind count).
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   tick       in   single-cycle step strobe
//   en         in   count enable (ticks ignored when low)
//   clear      in   synchronous clear to 0
//   up_down    in   0 = up, 1 = down
//   mode       in   0 wrap, 1 saturate, 2 one-shot, 3 reserved (wrap)
//   load       in   synchronous parallel load
//   load_val   in   load value, clamped to MAX_COUNT
//   count      out  current count (registered)
//   tc         out  terminal-count pulse, cycle after a boundary step
//   running    out  state is RUN
//   done       out  state is DONE (one-shot finished)
//   bcd_digits out  [COUNTER_BCD_OUT_EN only] decimal digits of count
// -----------------------------------------------------------------------------
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter  int unsigned MAX_COUNT = 9999,
    localparam int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             clear,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done
`ifdef COUNTER_BCD_OUT_EN
    ,
    output logic [4*ndigits(MAX_COUNT)-1:0] bcd_digits
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;
    logic             at_bound;

    always_comb begin
        step     = tick & en & (state_q == ST_RUN) & ~clear & ~load;
        at_bound = up_down ? (count_q == '0) : (count_q == MAX_V);

        count_d  = count_q;
        state_d  = state_q;
        tc_d     = 1'b0;

        if (clear) begin
            count_d = '0;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
            state_d = ST_RUN;
        end else if (step) begin
            if (!at_bound) begin
                count_d = up_down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end else begin
                tc_d = 1'b1;
                case (mode)
                    CNT_SAT:     count_d = count_q;
                    CNT_ONESHOT: state_d = ST_DONE;
                    // wrap and the reserved encoding jump to the opposite end
                    default:     count_d = up_down ? MAX_V : '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

`ifdef COUNTER_BCD_OUT_EN
    bin2bcd_reg #(
        .WIDTH (WIDTH),
        .NDIG  (ndigits(MAX_COUNT))
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .bin_i (count_q),
        .bcd_o (bcd_digits)
    );
`endif

endmodule
